ex_mem_pipe: RTL and testbench

EX_MEM_PIPE -- requirements
Module: ex_mem_pipe

---
 rtl/ex_mem_pipe.sv | 139 +++++++++++++
 tb/tb_ex_mem_pipe.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline register with stall/flush handling, a HALT sequencer,
// load-use hazard detection and an ALU-result forwarding enable.
module ex_mem_pipe #(
  parameter int unsigned DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          Stall,
  input  logic          Flush,
  input  logic          ex_Valid,
  input  logic          ex_Halt,
  input  logic [1:0]    ex_MemRW,
  input  logic [DW-1:0] ex_ALUOut,
  input  logic [DW-1:0] ex_Rt,
  input  logic [3:0]    ex_BrchCtrl,
  input  logic          ex_SF,
  input  logic          ex_ZF,
  input  logic          ex_OF,
  input  logic          ex_CF,
  input  logic          ex_RegWrEn,
  input  logic [2:0]    ex_WrReg,
  input  logic [2:0]    id_Rs,
  input  logic [2:0]    id_Rt,
  input  logic          id_RsUsed,
  input  logic          id_RtUsed,
  output logic          m_Valid,
  output logic          m_Halt,
  output logic [1:0]    m_MemRW,
  output logic [DW-1:0] m_ALUOut,
  output logic [DW-1:0] m_Rt,
  output logic [3:0]    m_BrchCtrl,
  output logic          m_SF,
  output logic          m_ZF,
  output logic          m_OF,
  output logic          m_CF,
  output logic          m_RegWrEn,
  output logic [2:0]    m_WrReg,
  output logic          LoadUseHaz,
  output logic          FwdEn,
  output logic          Frozen
);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_HALT1  = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  typedef struct packed {
    logic          valid;
    logic          halt;
    logic [1:0]    memrw;
    logic [DW-1:0] alu;
    logic [DW-1:0] rt;
    logic [3:0]    brch;
    logic          sf;
    logic          zf;
    logic          of;
    logic          cf;
    logic          regwren;
    logic [2:0]    wrreg;
  } mstage_t;

  state_t  r_state, w_state_nxt;
  mstage_t r_m, w_m_nxt, w_cap;

  // Captured slot: data passes raw, control bits only survive for real instructions.
  always_comb begin
    w_cap         = '0;
    w_cap.valid   = ex_Valid;
    w_cap.halt    = ex_Valid & ex_Halt;
    w_cap.memrw   = ex_Valid ? ex_MemRW : 2'b00;
    w_cap.alu     = ex_ALUOut;
    w_cap.rt      = ex_Rt;
    w_cap.brch    = ex_Valid ? ex_BrchCtrl : 4'h0;
    w_cap.sf      = ex_SF;
    w_cap.zf      = ex_ZF;
    w_cap.of      = ex_OF;
    w_cap.cf      = ex_CF;
    w_cap.regwren = ex_Valid & ex_RegWrEn;
    w_cap.wrreg   = ex_WrReg;
  end

  // Next-state and next-slot: Flush > Stall > capture while running; bubbles once halting.
  always_comb begin
    w_state_nxt = r_state;
    w_m_nxt     = r_m;
    case (r_state)
      S_RUN: begin
        if (Flush) begin
          w_m_nxt = '0;
        end else if (!Stall) begin
          w_m_nxt = w_cap;
          if (ex_Valid && ex_Halt) w_state_nxt = S_HALT1;
        end
      end
      S_HALT1: begin
        w_m_nxt     = '0;
        w_state_nxt = S_HALTED;
      end
      S_HALTED: w_m_nxt = '0;
      default: begin
        w_m_nxt     = '0;
        w_state_nxt = S_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_RUN;
      r_m     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_m     <= w_m_nxt;
    end
  end

  assign m_Valid    = r_m.valid;
  assign m_Halt     = r_m.halt;
  assign m_MemRW    = r_m.memrw;
  assign m_ALUOut   = r_m.alu;
  assign m_Rt       = r_m.rt;
  assign m_BrchCtrl = r_m.brch;
  assign m_SF       = r_m.sf;
  assign m_ZF       = r_m.zf;
  assign m_OF       = r_m.of;
  assign m_CF       = r_m.cf;
  assign m_RegWrEn  = r_m.regwren;
  assign m_WrReg    = r_m.wrreg;

  // A pure load (read without write) in MEM cannot forward until it returns.
  assign LoadUseHaz = r_m.valid & r_m.memrw[1] & ~r_m.memrw[0] & r_m.regwren &
                      ((id_RsUsed & (id_Rs == r_m.wrreg)) |
                       (id_RtUsed & (id_Rt == r_m.wrreg)));
  assign FwdEn      = r_m.valid & r_m.regwren & ~r_m.memrw[1];
  assign Frozen     = (r_state != S_RUN);

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Directed table-driven bench for ex_mem_pipe plus hand-written halt and
// asynchronous-reset sequences.
module tb_ex_mem_pipe;

  localparam int unsigned DW = 16;

  logic          clk, rst, Stall, Flush, ex_Valid, ex_Halt;
  logic [1:0]    ex_MemRW;
  logic [DW-1:0] ex_ALUOut, ex_Rt;
  logic [3:0]    ex_BrchCtrl;
  logic          ex_SF, ex_ZF, ex_OF, ex_CF, ex_RegWrEn;
  logic [2:0]    ex_WrReg, id_Rs, id_Rt;
  logic          id_RsUsed, id_RtUsed;
  logic          m_Valid, m_Halt;
  logic [1:0]    m_MemRW;
  logic [DW-1:0] m_ALUOut, m_Rt;
  logic [3:0]    m_BrchCtrl;
  logic          m_SF, m_ZF, m_OF, m_CF, m_RegWrEn;
  logic [2:0]    m_WrReg;
  logic          LoadUseHaz, FwdEn, Frozen;

  ex_mem_pipe #(.DW(DW)) dut (
    .clk(clk), .rst(rst), .Stall(Stall), .Flush(Flush),
    .ex_Valid(ex_Valid), .ex_Halt(ex_Halt), .ex_MemRW(ex_MemRW),
    .ex_ALUOut(ex_ALUOut), .ex_Rt(ex_Rt), .ex_BrchCtrl(ex_BrchCtrl),
    .ex_SF(ex_SF), .ex_ZF(ex_ZF), .ex_OF(ex_OF), .ex_CF(ex_CF),
    .ex_RegWrEn(ex_RegWrEn), .ex_WrReg(ex_WrReg),
    .id_Rs(id_Rs), .id_Rt(id_Rt), .id_RsUsed(id_RsUsed), .id_RtUsed(id_RtUsed),
    .m_Valid(m_Valid), .m_Halt(m_Halt), .m_MemRW(m_MemRW),
    .m_ALUOut(m_ALUOut), .m_Rt(m_Rt), .m_BrchCtrl(m_BrchCtrl),
    .m_SF(m_SF), .m_ZF(m_ZF), .m_OF(m_OF), .m_CF(m_CF),
    .m_RegWrEn(m_RegWrEn), .m_WrReg(m_WrReg),
    .LoadUseHaz(LoadUseHaz), .FwdEn(FwdEn), .Frozen(Frozen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic st, fl, v, h;
    logic [1:0] rw;
    logic [15:0] alu, rt;
    logic [3:0] br, flg;
    logic we;
    logic [2:0] wr, rs, rtid;
    logic rsu, rtu;
    logic ev;
    logic [1:0] erw;
    logic ewe;
    logic [3:0] ebr;
    logic cd;
    logic [15:0] ealu, ert;
    logic [2:0] ewr;
    logic [3:0] efl;
    logic elu, efw;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;
  vec_t vecs[14];

  function automatic vec_t mk(
    input logic st, fl, v, h, input logic [1:0] rw, input logic [15:0] alu, rt,
    input logic [3:0] br, flg, input logic we, input logic [2:0] wr, rs, rtid,
    input logic rsu, rtu,
    input logic ev, input logic [1:0] erw, input logic ewe, input logic [3:0] ebr,
    input logic cd, input logic [15:0] ealu, ert, input logic [2:0] ewr,
    input logic [3:0] efl, input logic elu, efw);
    vec_t t;
    t.st = st; t.fl = fl; t.v = v; t.h = h; t.rw = rw; t.alu = alu; t.rt = rt;
    t.br = br; t.flg = flg; t.we = we; t.wr = wr; t.rs = rs; t.rtid = rtid;
    t.rsu = rsu; t.rtu = rtu; t.ev = ev; t.erw = erw; t.ewe = ewe; t.ebr = ebr;
    t.cd = cd; t.ealu = ealu; t.ert = ert; t.ewr = ewr; t.efl = efl;
    t.elu = elu; t.efw = efw;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic st, fl, v, h, input logic [1:0] rw,
                       input logic [15:0] alu, rt, input logic [3:0] br, flg,
                       input logic we, input logic [2:0] wr, rs, rtid,
                       input logic rsu, rtu);
    Stall = st; Flush = fl; ex_Valid = v; ex_Halt = h; ex_MemRW = rw;
    ex_ALUOut = alu; ex_Rt = rt; ex_BrchCtrl = br;
    {ex_SF, ex_ZF, ex_OF, ex_CF} = flg;
    ex_RegWrEn = we; ex_WrReg = wr; id_Rs = rs; id_Rt = rtid;
    id_RsUsed = rsu; id_RtUsed = rtu;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".valid"},  32'(m_Valid), 32'd0);
    check({tag, ".halt"},   32'(m_Halt), 32'd0);
    check({tag, ".memrw"},  32'(m_MemRW), 32'd0);
    check({tag, ".regwr"},  32'(m_RegWrEn), 32'd0);
    check({tag, ".brch"},   32'(m_BrchCtrl), 32'd0);
    check({tag, ".alu"},    32'(m_ALUOut), 32'd0);
    check({tag, ".rt"},     32'(m_Rt), 32'd0);
    check({tag, ".wrreg"},  32'(m_WrReg), 32'd0);
    check({tag, ".flags"},  32'({m_SF, m_ZF, m_OF, m_CF}), 32'd0);
    check({tag, ".luh"},    32'(LoadUseHaz), 32'd0);
    check({tag, ".fwd"},    32'(FwdEn), 32'd0);
    check({tag, ".frozen"}, 32'(Frozen), 32'd0);
  endtask

  initial begin
    //            st fl v  h  rw     alu       rt        br    flg   we wr    rs    rtid  rsu rtu | ev erw    ewe ebr  cd ealu      ert       ewr   efl   elu efw
    vecs[0]  = mk(0, 0, 1, 0, 2'b01, 16'h1234, 16'hBEEF, 4'h3, 4'hA, 1, 3'd5, 3'd0, 3'd0, 0, 0,  1, 2'b01, 1, 4'h3, 1, 16'h1234, 16'hBEEF, 3'd5, 4'hA, 0, 1);
    vecs[1]  = mk(1, 0, 1, 0, 2'b10, 16'h1111, 16'h2222, 4'h7, 4'h5, 0, 3'd2, 3'd0, 3'd0, 0, 0,  1, 2'b01, 1, 4'h3, 1, 16'h1234, 16'hBEEF, 3'd5, 4'hA, 0, 1);
    vecs[2]  = mk(1, 0, 1, 0, 2'b10, 16'h3333, 16'h2222, 4'h7, 4'h5, 0, 3'd2, 3'd0, 3'd0, 0, 0,  1, 2'b01, 1, 4'h3, 1, 16'h1234, 16'hBEEF, 3'd5, 4'hA, 0, 1);
    vecs[3]  = mk(1, 0, 0, 0, 2'b11, 16'h4444, 16'h2222, 4'h7, 4'h5, 1, 3'd2, 3'd0, 3'd0, 0, 0,  1, 2'b01, 1, 4'h3, 1, 16'h1234, 16'hBEEF, 3'd5, 4'hA, 0, 1);
    vecs[4]  = mk(1, 1, 1, 0, 2'b01, 16'h5555, 16'h6666, 4'h1, 4'h0, 1, 3'd1, 3'd0, 3'd0, 0, 0,  0, 2'b00, 0, 4'h0, 0, 16'h0000, 16'h0000, 3'd0, 4'h0, 0, 0);
    vecs[5]  = mk(0, 0, 1, 0, 2'b10, 16'h0040, 16'h5555, 4'h0, 4'h3, 1, 3'd3, 3'd0, 3'd3, 0, 1,  1, 2'b10, 1, 4'h0, 1, 16'h0040, 16'h5555, 3'd3, 4'h3, 1, 0);
    vecs[6]  = mk(1, 0, 1, 0, 2'b01, 16'h9999, 16'h9999, 4'h0, 4'h0, 0, 3'd0, 3'd0, 3'd3, 0, 0,  1, 2'b10, 1, 4'h0, 1, 16'h0040, 16'h5555, 3'd3, 4'h3, 0, 0);
    vecs[7]  = mk(1, 0, 1, 0, 2'b01, 16'h9999, 16'h9999, 4'h0, 4'h0, 0, 3'd0, 3'd3, 3'd3, 1, 0,  1, 2'b10, 1, 4'h0, 1, 16'h0040, 16'h5555, 3'd3, 4'h3, 1, 0);
    vecs[8]  = mk(1, 0, 1, 0, 2'b01, 16'h9999, 16'h9999, 4'h0, 4'h0, 0, 3'd0, 3'd4, 3'd3, 1, 0,  1, 2'b10, 1, 4'h0, 1, 16'h0040, 16'h5555, 3'd3, 4'h3, 0, 0);
    vecs[9]  = mk(0, 0, 1, 0, 2'b11, 16'hAAAA, 16'h0F0F, 4'h2, 4'hF, 1, 3'd3, 3'd0, 3'd3, 0, 1,  1, 2'b11, 1, 4'h2, 1, 16'hAAAA, 16'h0F0F, 3'd3, 4'hF, 0, 0);
    vecs[10] = mk(0, 0, 0, 0, 2'b11, 16'h7777, 16'h8888, 4'hF, 4'h6, 1, 3'd6, 3'd0, 3'd6, 0, 1,  0, 2'b00, 0, 4'h0, 1, 16'h7777, 16'h8888, 3'd6, 4'h6, 0, 0);
    vecs[11] = mk(0, 0, 1, 0, 2'b00, 16'h0102, 16'h0304, 4'h9, 4'hC, 1, 3'd1, 3'd1, 3'd0, 1, 0,  1, 2'b00, 1, 4'h9, 1, 16'h0102, 16'h0304, 3'd1, 4'hC, 0, 1);
    vecs[12] = mk(0, 1, 1, 0, 2'b10, 16'hABCD, 16'hDCBA, 4'h4, 4'h1, 1, 3'd1, 3'd1, 3'd0, 1, 0,  0, 2'b00, 0, 4'h0, 0, 16'h0000, 16'h0000, 3'd0, 4'h0, 0, 0);
    vecs[13] = mk(0, 0, 1, 0, 2'b10, 16'h0001, 16'h0002, 4'h5, 4'h2, 0, 3'd7, 3'd0, 3'd7, 0, 1,  1, 2'b10, 0, 4'h5, 1, 16'h0001, 16'h0002, 3'd7, 4'h2, 0, 0);

    // Reset held with busy inputs: everything must stay cleared.
    rst = 1'b0;
    drive(0, 0, 1, 1, 2'b10, 16'hFFFF, 16'hFFFF, 4'hF, 4'hF, 1, 3'd2, 3'd2, 3'd2, 1, 1);
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].st, vecs[i].fl, vecs[i].v, vecs[i].h, vecs[i].rw, vecs[i].alu,
            vecs[i].rt, vecs[i].br, vecs[i].flg, vecs[i].we, vecs[i].wr,
            vecs[i].rs, vecs[i].rtid, vecs[i].rsu, vecs[i].rtu);
      @(posedge clk);
      #1;
      check($sformatf("v%0d.valid", i),  32'(m_Valid), 32'(vecs[i].ev));
      check($sformatf("v%0d.halt", i),   32'(m_Halt), 32'd0);
      check($sformatf("v%0d.memrw", i),  32'(m_MemRW), 32'(vecs[i].erw));
      check($sformatf("v%0d.regwr", i),  32'(m_RegWrEn), 32'(vecs[i].ewe));
      check($sformatf("v%0d.brch", i),   32'(m_BrchCtrl), 32'(vecs[i].ebr));
      check($sformatf("v%0d.luh", i),    32'(LoadUseHaz), 32'(vecs[i].elu));
      check($sformatf("v%0d.fwd", i),    32'(FwdEn), 32'(vecs[i].efw));
      check($sformatf("v%0d.frozen", i), 32'(Frozen), 32'd0);
      if (vecs[i].cd) begin
        check($sformatf("v%0d.alu", i),   32'(m_ALUOut), 32'(vecs[i].ealu));
        check($sformatf("v%0d.rt", i),    32'(m_Rt), 32'(vecs[i].ert));
        check($sformatf("v%0d.wrreg", i), 32'(m_WrReg), 32'(vecs[i].ewr));
        check($sformatf("v%0d.flags", i), 32'({m_SF, m_ZF, m_OF, m_CF}), 32'(vecs[i].efl));
      end
    end

    // HALT capture, then stalled and unstalled attempts to push more work.
    drive(0, 0, 1, 1, 2'b00, 16'hDEAD, 16'h0000, 4'h0, 4'h0, 0, 3'd0, 3'd0, 3'd0, 0, 0);
    @(posedge clk);
    #1;
    check("halt1.valid",  32'(m_Valid), 32'd1);
    check("halt1.halt",   32'(m_Halt), 32'd1);
    check("halt1.alu",    32'(m_ALUOut), 32'hDEAD);
    check("halt1.frozen", 32'(Frozen), 32'd1);
    drive(1, 0, 1, 0, 2'b01, 16'h4321, 16'h0000, 4'h1, 4'h0, 1, 3'd2, 3'd0, 3'd0, 0, 0);
    @(posedge clk);
    #1;
    check("halted.valid",  32'(m_Valid), 32'd0);
    check("halted.halt",   32'(m_Halt), 32'd0);
    check("halted.memrw",  32'(m_MemRW), 32'd0);
    check("halted.frozen", 32'(Frozen), 32'd1);
    drive(0, 0, 1, 1, 2'b10, 16'h4321, 16'h0000, 4'h1, 4'h0, 1, 3'd2, 3'd2, 3'd0, 1, 0);
    repeat (2) @(posedge clk);
    #1;
    check("halted2.valid",  32'(m_Valid), 32'd0);
    check("halted2.regwr",  32'(m_RegWrEn), 32'd0);
    check("halted2.luh",    32'(LoadUseHaz), 32'd0);
    check("halted2.fwd",    32'(FwdEn), 32'd0);
    check("halted2.frozen", 32'(Frozen), 32'd1);

    // Asynchronous reset mid-cycle while halted, then normal capture.
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("areset");
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 1, 0, 2'b00, 16'h5A5A, 16'hA5A5, 4'h6, 4'h9, 1, 3'd4, 3'd0, 3'd0, 0, 0);
    @(posedge clk);
    #1;
    check("resume.valid",  32'(m_Valid), 32'd1);
    check("resume.alu",    32'(m_ALUOut), 32'h5A5A);
    check("resume.rt",     32'(m_Rt), 32'hA5A5);
    check("resume.wrreg",  32'(m_WrReg), 32'd4);
    check("resume.fwd",    32'(FwdEn), 32'd1);
    check("resume.frozen", 32'(Frozen), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
